// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the XLEN constant, the req_size encodings and the responder FSM state type.
package dmem_pkg;

  localparam int unsigned XLEN = 32;

  // req_size encodings
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for the data-memory responder (purely combinational).
// Ports:
//   i_size        access size (SZ_BYTE/SZ_HALF/SZ_WORD; SZ_ILL handled as word)
//   i_unsigned    zero-extend loads instead of sign-extending
//   i_addr_lo     byte offset within the word
//   i_wdata       right-aligned store data
//   i_rword       storage word being read
//   o_wmask       byte lanes written by a store
//   o_wdata_lane  store data replicated onto its lanes
//   o_rdata_ext   extracted and extended load data
// Misaligned half/word offsets are aligned down here; fault detection is done by the caller.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rword,
  output logic [3:0]      o_wmask,
  output logic [XLEN-1:0] o_wdata_lane,
  output logic [XLEN-1:0] o_rdata_ext
);

  logic [XLEN-1:0] w_byte_shift;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  assign w_byte_shift = i_rword >> {i_addr_lo, 3'b000};
  assign w_byte       = w_byte_shift[7:0];
  assign w_half       = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    o_wmask      = 4'b1111;
    o_wdata_lane = i_wdata;
    o_rdata_ext  = i_rword;
    case (i_size)
      SZ_BYTE: begin
        o_wmask      = 4'b0001 << i_addr_lo;
        o_wdata_lane = {4{i_wdata[7:0]}};
        o_rdata_ext  = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_wmask      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata_lane = {2{i_wdata[15:0]}};
        o_rdata_ext  = {{16{~i_unsigned & w_half[15]}}, w_half};
      end
      default: begin
        o_wmask      = 4'b1111;
        o_wdata_lane = i_wdata;
        o_rdata_ext  = i_rword;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder over a word-organised storage array.
// A request is accepted in IDLE, waits WAIT_CYCLES cycles, commits the access and then holds
// the response until the initiator takes it.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/req_wdata  request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                               response channel
// Optional macro DMEM_ERR_EN: fault misaligned, size-11 and out-of-range accesses
// (no write, rsp_err=1, rsp_rdata=0). Without it addresses wrap and misalignment is ignored.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam bit          NoWait = (WAIT_CYCLES == 0);
  // WAIT lasts WAIT_CYCLES cycles; the commit edge is the one that sees the counter at 0.
  localparam logic [3:0]  CntInit = NoWait ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e          r_state, w_state_next;
  logic [3:0]      r_cnt, w_cnt_next;

  logic            r_we, r_unsigned;
  logic [1:0]      r_size;
  logic [XLEN-1:0] r_addr, r_wdata;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;

  logic [XLEN-1:0] r_mem [DEPTH_WORDS];

  logic            w_accept, w_commit, w_write, w_err, w_live;
  logic            w_we, w_unsigned;
  logic [1:0]      w_size;
  logic [XLEN-1:0] w_addr, w_wdata, w_rword, w_wdata_lane, w_rdata_ext;
  logic [AW-1:0]   w_idx;
  logic [3:0]      w_wmask;

  assign w_accept = req_valid & req_ready;

  // With no wait states the commit happens on the acceptance edge, so use the live request.
  assign w_live     = (r_state == StIdle);
  assign w_we       = w_live ? req_we       : r_we;
  assign w_size     = w_live ? req_size     : r_size;
  assign w_unsigned = w_live ? req_unsigned : r_unsigned;
  assign w_addr     = w_live ? req_addr     : r_addr;
  assign w_wdata    = w_live ? req_wdata    : r_wdata;
  assign w_idx      = w_addr[2 +: AW];

  assign w_commit = (w_live & w_accept & NoWait) | ((r_state == StWait) & (r_cnt == 4'd0));

`ifdef DMEM_ERR_EN
  logic w_out_of_range;
  assign w_out_of_range = (w_addr >> (AW + 2)) != '0;
  assign w_err = (w_size == SZ_ILL)
               | ((w_size == SZ_HALF) & w_addr[0])
               | ((w_size == SZ_WORD) & (w_addr[1:0] != 2'b00))
               | w_out_of_range;
`else
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^w_addr[XLEN-1:AW+2];
  assign w_err = 1'b0;
`endif

  // Gate with reset so nothing reaches storage while reset is held.
  assign w_write = w_commit & w_we & ~w_err & reset;
  assign w_rword = r_mem[w_idx];

  dmem_lane_align u_lane_align (
    .i_size       (w_size),
    .i_unsigned   (w_unsigned),
    .i_addr_lo    (w_addr[1:0]),
    .i_wdata      (w_wdata),
    .i_rword      (w_rword),
    .o_wmask      (w_wmask),
    .o_wdata_lane (w_wdata_lane),
    .o_rdata_ext  (w_rdata_ext)
  );

  // Storage is never reset.
  always_ff @(posedge clk) begin
    if (w_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wmask[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_lane[8*i +: 8];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      StIdle: begin
        if (req_valid) begin
          if (NoWait) begin
            w_state_next = StResp;
          end else begin
            w_state_next = StWait;
            w_cnt_next   = CntInit;
          end
        end
      end
      StWait: begin
        if (r_cnt == 4'd0) w_state_next = StResp;
        else               w_cnt_next   = r_cnt - 4'd1;
      end
      StResp: begin
        if (rsp_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready = (r_state == StIdle);
    rsp_valid = (r_state == StResp);
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // Request capture and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we       <= 1'b0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we       <= req_we;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
      end
      if (w_commit) begin
        r_rdata <= (w_we | w_err) ? '0 : w_rdata_ext;
        r_err   <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with WAIT_CYCLES=1 (table of transactions plus
// stall and reset-abort sequences) and one with WAIT_CYCLES=0 (back-to-back requests).
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int unsigned Wait1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // WAIT_CYCLES=1 instance
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;

  // WAIT_CYCLES=0 instance
  logic        req_valid_z = 1'b0, req_ready_z, req_we_z = 1'b0, req_unsigned_z = 1'b0;
  logic [1:0]  req_size_z = 2'b00;
  logic [31:0] req_addr_z = '0, req_wdata_z = '0;
  logic        rsp_valid_z, rsp_ready_z = 1'b1, rsp_err_z;
  logic [31:0] rsp_rdata_z;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(Wait1)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_we(req_we_z), .req_size(req_size_z),
    .req_unsigned(req_unsigned_z), .req_addr(req_addr_z), .req_wdata(req_wdata_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z),
    .rsp_err(rsp_err_z)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name, input logic [31:0] rd, input logic er);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: response with empty scoreboard", name);
      return;
    end
    e = sb.pop_front();
    chk({name, "_rdata"}, rd, e.rdata);
    chk({name, "_err"}, {31'd0, er}, {31'd0, e.err});
  endtask

  task automatic add(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input logic er);
    vec_t v;
    v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd; v.rdata = rd; v.err = er;
    vecs.push_back(v);
  endtask

  // Entered and left at #1 after a rising edge with the instance idle and rsp_ready=1.
  task automatic run_txn(input string name, input vec_t t);
    int n;
    req_we = t.we; req_size = t.size; req_unsigned = t.uns;
    req_addr = t.addr; req_wdata = t.wdata; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      chk({name, "_accept_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back('{rdata: t.rdata, err: t.err});
    #1;
    // Scramble the request fields: the latched copy must be used.
    req_valid = 1'b0; req_we = ~t.we; req_addr = $urandom; req_wdata = $urandom;
    req_size = ~t.size; req_unsigned = ~t.uns;
    n = 1;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({name, "_latency"}, n, Wait1 + 1);
    if (rsp_valid) pop_chk(name, rsp_rdata, rsp_err);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc_prev;
    logic [31:0] ex;

    // Transaction table: {we, size, unsigned, addr, wdata, expected rdata, expected err}
    add(1, SZ_WORD, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    add(0, SZ_WORD, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    add(1, SZ_BYTE, 0, 32'h11,  32'hABCDEF80, 32'h0,        0);
    add(0, SZ_BYTE, 0, 32'h11,  32'h0,        32'hFFFFFF80, 0);
    add(0, SZ_BYTE, 1, 32'h11,  32'h0,        32'h00000080, 0);
    add(0, SZ_WORD, 0, 32'h10,  32'h0,        32'hDEAD80EF, 0);
    add(1, SZ_WORD, 0, 32'h20,  32'hA5A5A5A5, 32'h0,        0);
    add(1, SZ_HALF, 0, 32'h22,  32'h1234F00D, 32'h0,        0);
    add(0, SZ_WORD, 0, 32'h20,  32'h0,        32'hF00DA5A5, 0);
    add(0, SZ_HALF, 0, 32'h22,  32'h0,        32'hFFFFF00D, 0);
    add(0, SZ_HALF, 1, 32'h22,  32'h0,        32'h0000F00D, 0);
    add(0, SZ_HALF, 0, 32'h20,  32'h0,        32'hFFFFA5A5, 0);
    add(0, SZ_BYTE, 0, 32'h23,  32'h0,        32'hFFFFFFF0, 0);
    add(1, SZ_BYTE, 0, 32'h21,  32'h0000007F, 32'h0,        0);
    add(0, SZ_BYTE, 0, 32'h21,  32'h0,        32'h0000007F, 0);
    add(1, SZ_WORD, 0, 32'h0,   32'h0BADF00D, 32'h0,        0);
`ifdef DMEM_ERR_EN
    add(0, SZ_HALF, 0, 32'h13,  32'h0,        32'h0,        1);
    add(0, SZ_ILL,  0, 32'h10,  32'h0,        32'h0,        1);
    add(0, SZ_WORD, 0, 32'h12,  32'h0,        32'h0,        1);
    add(1, SZ_WORD, 0, 32'h400, 32'h11112222, 32'h0,        1);
    add(0, SZ_WORD, 0, 32'h0,   32'h0,        32'h0BADF00D, 0);
`else
    add(0, SZ_HALF, 0, 32'h13,  32'h0,        32'hFFFFDEAD, 0);
    add(0, SZ_ILL,  0, 32'h10,  32'h0,        32'hDEAD80EF, 0);
    add(0, SZ_WORD, 0, 32'h12,  32'h0,        32'hDEAD80EF, 0);
    add(1, SZ_WORD, 0, 32'h400, 32'h11112222, 32'h0,        0);
    add(0, SZ_WORD, 0, 32'h0,   32'h0,        32'h11112222, 0);
`endif

    // Reset
    #2 rst_n = 1'b0;
    #1;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset_rsp_valid_z", {31'd0, rsp_valid_z}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_req_ready_z", {31'd0, req_ready_z}, 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Response stall with a new request held on the input
    rsp_ready = 1'b0;
    req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk);
    sb.push_back('{rdata: 32'hDEAD80EF, err: 1'b0});
    #1;
    req_we = 1'b1; req_size = SZ_BYTE; req_addr = 32'h10; req_wdata = 32'h00000055;
    n = 1;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("stall_latency", n, 32'd2);
    ex = (sb.size() != 0) ? sb[0].rdata : 32'hx;
    pop_chk("stall_first", rsp_rdata, rsp_err);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("stall%0d_rdata", k), rsp_rdata, ex);
      chk($sformatf("stall%0d_err", k), {31'd0, rsp_err}, 32'd0);
      chk($sformatf("stall%0d_req_ready", k), {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("stall_hs_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    #1;
    chk("stall_next_accepted", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("stall_next_latency", n, 32'd2);
    pop_chk("stall_next", rsp_rdata, rsp_err);
    @(posedge clk); #1;
    run_txn("stall_readback", '{we: 1'b0, size: SZ_WORD, uns: 1'b0, addr: 32'h10,
                                wdata: 32'h0, rdata: 32'hDEAD8055, err: 1'b0});

    // Reset during WAIT of a store aborts it
    req_we = 1'b1; req_size = SZ_WORD; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h12345678; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_in_wait", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_rsp_rdata", rsp_rdata, 32'd0);
    chk("abort_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    run_txn("abort_readback", '{we: 1'b0, size: SZ_WORD, uns: 1'b0, addr: 32'h20,
                                wdata: 32'h0, rdata: 32'hF00D7FA5, err: 1'b0});

    // Zero wait states, back-to-back requests, rsp_ready tied high
    vecs.delete();
    add(1, SZ_WORD, 0, 32'h40, 32'hCAFEF00D, 32'h0,        0);
    add(0, SZ_WORD, 0, 32'h40, 32'h0,        32'hCAFEF00D, 0);
    add(1, SZ_BYTE, 0, 32'h41, 32'h00000001, 32'h0,        0);
    add(0, SZ_WORD, 0, 32'h40, 32'h0,        32'hCAFE010D, 0);
    acc_prev = 0;
    req_valid_z = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      req_we_z = vecs[i].we; req_size_z = vecs[i].size; req_unsigned_z = vecs[i].uns;
      req_addr_z = vecs[i].addr; req_wdata_z = vecs[i].wdata;
      n = 0;
      while (!req_ready_z && n < 20) begin @(posedge clk); #1; n++; end
      if (!req_ready_z) begin
        chk($sformatf("b2b%0d_accept_timeout", i), 32'd0, 32'd1);
        break;
      end
      @(posedge clk);
      sb.push_back('{rdata: vecs[i].rdata, err: vecs[i].err});
      #1;
      if (i > 0) chk($sformatf("b2b%0d_spacing", i), cyc - acc_prev, 32'd2);
      acc_prev = cyc;
      chk($sformatf("b2b%0d_rsp_valid", i), {31'd0, rsp_valid_z}, 32'd1);
      chk($sformatf("b2b%0d_req_ready", i), {31'd0, req_ready_z}, 32'd0);
      if (rsp_valid_z) pop_chk($sformatf("b2b%0d", i), rsp_rdata_z, rsp_err_z);
      @(posedge clk); #1;
    end
    req_valid_z = 1'b0;
    @(posedge clk); #1;
    chk("b2b_done_idle", {31'd0, rsp_valid_z}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
